// File: rtl/cmsdk_my_input_stage.sv
// cmsdk_my_input_stage
// Per-master input stage of the AHB bus matrix. Each valid address phase from
// the master is captured in a one-entry holding register. If the output stage
// cannot take the transfer in the same cycle, the held copy is presented to
// the output stage and the master is stalled. Once the transfer is accepted,
// the slave's data-phase HREADYOUT/HRESP are returned to the master.
//
// Ports:
//   HCLK, HRESET            clock, asynchronous active-high reset
//   HSELS..HMASTLOCKS       master-side address phase
//   HREADYS                 master-bus HREADY (qualifies the address phase)
//   HREADYOUTS, HRESPS      ready/response returned to the master
//   sel_ip..mastlock_ip     address/control routed to the output stage
//   held_tran_ip            transfer request to the output stage
//   active_ip               output stage has granted this port
//   readymux_ip             output-stage HREADYMUXM
//   readyout_ip, resp_ip    slave HREADYOUT/HRESP for this port's data phase
module cmsdk_my_input_stage (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSELS,
   input  logic [31:0] HADDRS,
   input  logic [31:0] HAUSERS,
   input  logic [1:0]  HTRANSS,
   input  logic        HWRITES,
   input  logic [2:0]  HSIZES,
   input  logic [2:0]  HBURSTS,
   input  logic [3:0]  HPROTS,
   input  logic [3:0]  HMASTERS,
   input  logic        HMASTLOCKS,
   input  logic        HREADYS,
   output logic        HREADYOUTS,
   output logic [1:0]  HRESPS,
   output logic        sel_ip,
   output logic [31:0] addr_ip,
   output logic [31:0] auser_ip,
   output logic [1:0]  trans_ip,
   output logic        write_ip,
   output logic [2:0]  size_ip,
   output logic [2:0]  burst_ip,
   output logic [3:0]  prot_ip,
   output logic [3:0]  master_ip,
   output logic        mastlock_ip,
   output logic        held_tran_ip,
   input  logic        active_ip,
   input  logic        readymux_ip,
   input  logic        readyout_ip,
   input  logic [1:0]  resp_ip
);

   // Holding register
   logic [31:0] addr_q,     addr_d;
   logic [31:0] auser_q,    auser_d;
   logic [1:0]  trans_q,    trans_d;
   logic        write_q,    write_d;
   logic [2:0]  size_q,     size_d;
   logic [2:0]  burst_q,    burst_d;
   logic [3:0]  prot_q,     prot_d;
   logic [3:0]  master_q,   master_d;
   logic        mastlock_q, mastlock_d;

   logic        pend_q,       pend_d;
   logic        data_phase_q, data_phase_d;

   logic        addr_valid;
   logic        accept;

   // NONSEQ/SEQ only; IDLE and BUSY never need the output stage.
   assign addr_valid = HSELS & HTRANSS[1] & HREADYS;

   always_comb begin
      held_tran_ip = pend_q | addr_valid;
      accept       = held_tran_ip & active_ip & readymux_ip;

      // Capture every valid address phase; it is only used if pend gets set.
      addr_d     = addr_q;
      auser_d    = auser_q;
      trans_d    = trans_q;
      write_d    = write_q;
      size_d     = size_q;
      burst_d    = burst_q;
      prot_d     = prot_q;
      master_d   = master_q;
      mastlock_d = mastlock_q;
      if (addr_valid) begin
         addr_d     = HADDRS;
         auser_d    = HAUSERS;
         trans_d    = HTRANSS;
         write_d    = HWRITES;
         size_d     = HSIZES;
         burst_d    = HBURSTS;
         prot_d     = HPROTS;
         master_d   = HMASTERS;
         mastlock_d = HMASTLOCKS;
      end

      // Accept wins over a new address phase: same-cycle accept needs no hold.
      pend_d = pend_q;
      if (accept) begin
         pend_d = 1'b0;
      end else if (addr_valid) begin
         pend_d = 1'b1;
      end

      // Data phase advances only when the selected slave completes.
      data_phase_d = readymux_ip ? accept : data_phase_q;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         addr_q       <= '0;
         auser_q      <= '0;
         trans_q      <= '0;
         write_q      <= 1'b0;
         size_q       <= '0;
         burst_q      <= '0;
         prot_q       <= '0;
         master_q     <= '0;
         mastlock_q   <= 1'b0;
         pend_q       <= 1'b0;
         data_phase_q <= 1'b0;
      end else begin
         addr_q       <= addr_d;
         auser_q      <= auser_d;
         trans_q      <= trans_d;
         write_q      <= write_d;
         size_q       <= size_d;
         burst_q      <= burst_d;
         prot_q       <= prot_d;
         master_q     <= master_d;
         mastlock_q   <= mastlock_d;
         pend_q       <= pend_d;
         data_phase_q <= data_phase_d;
      end
   end

   // Output stage sees the held copy while pending, otherwise the live bus.
   always_comb begin
      if (pend_q) begin
         sel_ip      = 1'b1;
         addr_ip     = addr_q;
         auser_ip    = auser_q;
         trans_ip    = trans_q;
         write_ip    = write_q;
         size_ip     = size_q;
         burst_ip    = burst_q;
         prot_ip     = prot_q;
         master_ip   = master_q;
         mastlock_ip = mastlock_q;
      end else begin
         sel_ip      = HSELS & HREADYS;
         addr_ip     = HADDRS;
         auser_ip    = HAUSERS;
         trans_ip    = HTRANSS;
         write_ip    = HWRITES;
         size_ip     = HSIZES;
         burst_ip    = HBURSTS;
         prot_ip     = HPROTS;
         master_ip   = HMASTERS;
         mastlock_ip = HMASTLOCKS;
      end
   end

   always_comb begin
      if (pend_q) begin
         HREADYOUTS = 1'b0;
      end else if (data_phase_q) begin
         HREADYOUTS = readyout_ip;
      end else begin
         HREADYOUTS = 1'b1;
      end
      HRESPS = data_phase_q ? resp_ip : 2'b00;
   end

endmodule
